// File: rtl/ram_uart_loader_pkg.sv
// -----------------------------------------------------------------------------
// ram_uart_loader_pkg
// Shared types and constants for the UART-driven RAM loader:
//   - cmd_state_e : command FSM states (top module)
//   - rx_state_e  : UART receiver bit-level states (uart_rx_byte)
//   - OP_WRITE / OP_READ opcodes and the ACK_BYTE response
//   - accepts_byte(): states in which an incoming byte is consumed by the FSM
// -----------------------------------------------------------------------------
package ram_uart_loader_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
    localparam logic [7:0] ACK_BYTE = 8'h06;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_ACK,
        S_READ_REQ,
        S_READ_WAIT,
        S_TX_HI,
        S_TX_LO
    } cmd_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Bytes arriving outside these states have nowhere to go and are dropped.
    function automatic logic accepts_byte(input cmd_state_e s);
        return (s == S_IDLE)    || (s == S_ADDR_HI) || (s == S_ADDR_LO) ||
               (s == S_DATA_HI) || (s == S_DATA_LO);
    endfunction

endpackage

// File: rtl/ram_uart_loader_uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART receiver: 2-flop synchroniser, falling-edge start detection,
// mid-bit sampling, stop-bit framing check.
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   rx_i        in   asynchronous UART line, idle high
//   byte_o      out  last good received byte (valid with byte_stb_o)
//   byte_stb_o  out  1-cycle pulse per good byte
//   frame_err_o out  1-cycle pulse when the stop bit samples low
// -----------------------------------------------------------------------------
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_stb_o,
    output logic       frame_err_o
);
    import ram_uart_loader_pkg::*;

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic rx_meta_q, rx_sync_q, rx_prev_q;

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             stb_q, stb_d;
    logic             ferr_q, ferr_d;

    // Synchroniser resets high so reset release never looks like a start edge.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // NOTE: the shift register and byte holder are reset too; they are small
    // flops, not a memory array, and a defined byte_o after reset costs nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            stb_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            stb_q   <= stb_d;
            ferr_q  <= ferr_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        stb_d   = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // Half a bit in: a high line means a glitch, abort quietly.
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};  // LSB arrives first
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        byte_d = shift_q;
                        stb_d  = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_o      = byte_q;
    assign byte_stb_o  = stb_q;
    assign frame_err_o = ferr_q;

endmodule

// File: rtl/ram_uart_loader.sv
// -----------------------------------------------------------------------------
// ram_uart_loader
// Decodes UART command streams into block-RAM accesses and streams read data
// back toward a UART transmitter.
//   'W' AH AL DH DL : write {DH,DL} to {AH,AL}[ADDR_W-1:0]
//   'R' AH AL       : read word, return high byte then low byte
// Optional build macro: RAM_UART_LOADER_ACK_EN -- when defined, each write is
// answered with a single ACK_BYTE (0x06) on the TX handshake.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   rx                asynchronous UART input, idle high
//   wraddr/di/wren    RAM write port (wren is a 1-cycle pulse)
//   rdaddr/rden/do_i  RAM read port (do_i valid 1 cycle after rden); the read
//                     data port is do_i because 'do' is a reserved word
//   tx_data/tx_valid/tx_ready  response byte stream, valid/ready handshake
//   err               sticky framing / dropped-byte flag, cleared by rst
// -----------------------------------------------------------------------------
module ram_uart_loader #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115_200,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [ADDR_W-1:0] wraddr,
    output logic [DATA_W-1:0] di,
    output logic              wren,
    output logic [ADDR_W-1:0] rdaddr,
    output logic              rden,
    input  logic [DATA_W-1:0] do_i,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              err
);
    import ram_uart_loader_pkg::*;

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    logic [7:0] rx_byte;
    logic       rx_stb;
    logic       rx_ferr;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (rx),
        .byte_o     (rx_byte),
        .byte_stb_o (rx_stb),
        .frame_err_o(rx_ferr)
    );

    cmd_state_e        state_q, state_d;
    logic              is_wr_q, is_wr_d;
    logic [7:0]        addr_hi_q, addr_hi_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_hi_q, data_hi_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            is_wr_q   <= 1'b0;
            addr_hi_q <= '0;
            addr_q    <= '0;
            data_hi_q <= '0;
            data_q    <= '0;
            hold_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            addr_hi_q <= addr_hi_d;
            addr_q    <= addr_d;
            data_hi_q <= data_hi_d;
            data_q    <= data_d;
            hold_q    <= hold_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        addr_hi_d = addr_hi_q;
        addr_d    = addr_q;
        data_hi_d = data_hi_q;
        data_d    = data_q;
        hold_d    = hold_q;
        err_d     = err_q | rx_ferr;
        wren      = 1'b0;
        rden      = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;

        // A byte the FSM cannot consume is lost; flag it, leave the FSM alone.
        if (rx_stb && !accepts_byte(state_q)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (rx_stb && (rx_byte == OP_WRITE || rx_byte == OP_READ)) begin
                    is_wr_d = (rx_byte == OP_WRITE);
                    state_d = S_ADDR_HI;
                end
            end
            S_ADDR_HI: begin
                if (rx_stb) begin
                    addr_hi_d = rx_byte;
                    state_d   = S_ADDR_LO;
                end
            end
            S_ADDR_LO: begin
                if (rx_stb) begin
                    // Truncation drops address bits above ADDR_W on purpose.
                    addr_d  = ADDR_W'({addr_hi_q, rx_byte});
                    state_d = is_wr_q ? S_DATA_HI : S_READ_REQ;
                end
            end
            S_DATA_HI: begin
                if (rx_stb) begin
                    data_hi_d = rx_byte;
                    state_d   = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (rx_stb) begin
                    data_d  = {data_hi_q, rx_byte};
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                wren = 1'b1;
`ifdef RAM_UART_LOADER_ACK_EN
                state_d = S_ACK;
`else
                state_d = S_IDLE;
`endif
            end
            S_ACK: begin
                tx_valid = 1'b1;
                tx_data  = ACK_BYTE;
                if (tx_ready) state_d = S_IDLE;
            end
            S_READ_REQ: begin
                rden    = 1'b1;
                state_d = S_READ_WAIT;
            end
            S_READ_WAIT: begin
                hold_d  = do_i;
                state_d = S_TX_HI;
            end
            S_TX_HI: begin
                tx_valid = 1'b1;
                tx_data  = hold_q[15:8];
                if (tx_ready) state_d = S_TX_LO;
            end
            S_TX_LO: begin
                tx_valid = 1'b1;
                tx_data  = hold_q[7:0];
                if (tx_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One address register serves both ports; it only changes while a
    // command is being assembled, never during a strobe.
    assign wraddr = addr_q;
    assign rdaddr = addr_q;
    assign di     = data_q;
    assign err    = err_q;

endmodule

// File: tb/tb_ram_uart_loader.sv
// -----------------------------------------------------------------------------
// tb_ram_uart_loader
// Bench for ram_uart_loader at 10 clocks per UART bit, with an attached RAM
// and a reference memory kept as a plain associative array.
// -----------------------------------------------------------------------------
module tb_ram_uart_loader;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
`ifdef RAM_UART_LOADER_ACK_EN
    localparam int ACK_ON = 1;
`else
    localparam int ACK_ON = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              rx;
    logic [ADDR_W-1:0] wraddr;
    logic [DATA_W-1:0] di;
    logic              wren;
    logic [ADDR_W-1:0] rdaddr;
    logic              rden;
    logic [DATA_W-1:0] ram_do;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              err;

    always #5 clk = ~clk;

    ram_uart_loader #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .wraddr  (wraddr),
        .di      (di),
        .wren    (wren),
        .rdaddr  (rdaddr),
        .rden    (rden),
        .do_i    (ram_do),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .err     (err)
    );

    // ram0: simple synchronous block RAM on the DUT ports.
    logic [DATA_W-1:0] ram0 [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (wren) ram0[wraddr] <= di;
        if (rden) ram_do <= ram0[rdaddr];
    end

    // Event logs sampled on the falling edge.
    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t               wr_q[$];
    logic [ADDR_W-1:0] rd_q[$];
    logic [7:0]        tx_q[$];
    int                cyc = 0;
    int                rd_cyc = 0;
    int                tv_cyc = 0;
    logic              tv_prev = 1'b0;
    logic              both_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wren) wr_q.push_back('{wraddr, di});
        if (rden) begin
            rd_q.push_back(rdaddr);
            rd_cyc <= cyc;
        end
        if (tx_valid && !tv_prev) tv_cyc <= cyc;
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (wren && rden) both_seen <= 1'b1;
        tv_prev <= tx_valid;
    end

    // Reference model: word memory indexed by the effective address.
    logic [15:0] ref_mem [int];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        wr_q.delete();
        rd_q.delete();
        tx_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB);
        rx = 1'b1;
        tick(CPB);
    endtask

    function automatic int eff_addr(input logic [7:0] hi, input logic [7:0] lo);
        return (int'(hi) * 256 + int'(lo)) % (1 << ADDR_W);
    endfunction

    task automatic do_write(input logic [7:0] hi, input logic [7:0] lo,
                            input logic [7:0] dh, input logic [7:0] dl);
        send_byte(8'h57);
        send_byte(hi);
        send_byte(lo);
        send_byte(dh);
        send_byte(dl);
        tick(20);
        ref_mem[eff_addr(hi, lo)] = {dh, dl};
    endtask

    task automatic do_read(input logic [7:0] hi, input logic [7:0] lo);
        send_byte(8'h52);
        send_byte(hi);
        send_byte(lo);
        tick(20);
    endtask

    task automatic check_write(input string tag, input int exp_a, input logic [15:0] exp_d);
        check({tag, "_wren_cnt"}, 32'(wr_q.size()), 32'd1);
        check({tag, "_wraddr"}, (wr_q.size() > 0) ? 32'(wr_q[0].a) : 32'hDEAD_BEEF, 32'(exp_a));
        check({tag, "_di"}, (wr_q.size() > 0) ? 32'(wr_q[0].d) : 32'hDEAD_BEEF, 32'(exp_d));
        check({tag, "_rden_cnt"}, 32'(rd_q.size()), 32'd0);
        check({tag, "_tx_cnt"}, 32'(tx_q.size()), 32'(ACK_ON));
`ifdef RAM_UART_LOADER_ACK_EN
        check({tag, "_ack"}, (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'hDEAD_BEEF, 32'h06);
`endif
    endtask

    task automatic check_read(input string tag, input int exp_a, input logic [15:0] exp_d);
        check({tag, "_rden_cnt"}, 32'(rd_q.size()), 32'd1);
        check({tag, "_rdaddr"}, (rd_q.size() > 0) ? 32'(rd_q[0]) : 32'hDEAD_BEEF, 32'(exp_a));
        check({tag, "_tx_cnt"}, 32'(tx_q.size()), 32'd2);
        check({tag, "_tx_hi"}, (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'hDEAD_BEEF, 32'(exp_d[15:8]));
        check({tag, "_tx_lo"}, (tx_q.size() > 1) ? 32'(tx_q[1]) : 32'hDEAD_BEEF, 32'(exp_d[7:0]));
        check({tag, "_wren_cnt"}, 32'(wr_q.size()), 32'd0);
        check({tag, "_latency"}, 32'(tv_cyc - rd_cyc), 32'd2);
    endtask

    initial begin
        logic [7:0]  hi, lo, hi2;
        logic [15:0] d;
        int          a;
        int          hold_bad;

        rx       = 1'b1;
        tx_ready = 1'b1;
        rst      = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(1);

        // Reset state
        check("rst_wren", 32'(wren), 32'd0);
        check("rst_rden", 32'(rden), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wraddr", 32'(wraddr), 32'd0);
        check("rst_rdaddr", 32'(rdaddr), 32'd0);
        check("rst_di", 32'(di), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);

        // Basic write and read
        clear_logs();
        do_write(8'h01, 8'h23, 8'hBE, 8'hEF);
        check_write("wr_basic", 'h123, 16'hBEEF);

        clear_logs();
        do_write(8'h00, 8'h05, 8'h0F, 8'h0F);
        check_write("wr_05", 'h005, 16'h0F0F);
        clear_logs();
        do_read(8'h00, 8'h05);
        check_read("rd_05", 'h005, ref_mem[5]);

        // Back-pressure: tx_data must hold; a byte arriving now is dropped.
        clear_logs();
        do_write(8'h00, 8'h06, 8'hA5, 8'h5A);
        clear_logs();
        tx_ready = 1'b0;
        do_read(8'h00, 8'h06);
        for (int i = 0; i < 100 && !tx_valid; i++) tick(1);
        check("stall_valid", 32'(tx_valid), 32'd1);
        check("stall_data", 32'(tx_data), 32'hA5);
        hold_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (tx_data !== 8'hA5 || tx_valid !== 1'b1) hold_bad++;
        end
        check("stall_hold", 32'(hold_bad), 32'd0);
        check("stall_err_before", 32'(err), 32'd0);
        send_byte(8'h33);
        check("drop_err", 32'(err), 32'd1);
        check("drop_data_kept", 32'(tx_data), 32'hA5);
        check("drop_no_tx", 32'(tx_q.size()), 32'd0);
        tx_ready = 1'b1;
        tick(5);
        check_read("rd_stall", 'h006, ref_mem[6]);

        // Reset clears err
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("err_cleared", 32'(err), 32'd0);

        // Framing error: bad-stop 'W' must not start a command
        clear_logs();
        send_byte(8'h57, 1'b0);
        tick(20);
        check("ferr_err", 32'(err), 32'd1);
        check("ferr_no_wren", 32'(wr_q.size()), 32'd0);
        check("ferr_no_rden", 32'(rd_q.size()), 32'd0);

        // Unknown opcode ignored, following write still works
        send_byte(8'h41);
        do_write(8'h02, 8'h00, 8'h12, 8'h34);
        check_write("wr_after_bad", 'h200, 16'h1234);

        // Top address and ignored upper address bits
        clear_logs();
        do_write(8'h03, 8'hFF, 8'hC3, 8'h3C);
        check_write("wr_3ff", 'h3FF, 16'hC33C);
        clear_logs();
        do_read(8'hFF, 8'hFF);
        check_read("rd_ffff", 'h3FF, ref_mem[eff_addr(8'h03, 8'hFF)]);

        // Reset mid-command loses the partial command
        clear_logs();
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h10);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(20);
        check("rst_mid_no_wren", 32'(wr_q.size()), 32'd0);
        clear_logs();
        do_write(8'h00, 8'h10, 8'h55, 8'hAA);
        check_write("wr_after_rst", 'h010, 16'h55AA);

        // Randomized write/read-back against the reference memory
        for (int n = 0; n < 4; n++) begin
            hi  = 8'($urandom);
            lo  = 8'($urandom);
            d   = 16'($urandom);
            a   = eff_addr(hi, lo);
            clear_logs();
            do_write(hi, lo, d[15:8], d[7:0]);
            check_write($sformatf("rnd%0d_wr", n), a, d);
            hi2 = {6'($urandom), hi[1:0]};
            clear_logs();
            do_read(hi2, lo);
            check_read($sformatf("rnd%0d_rd", n), a, ref_mem[a]);
        end

        check("wren_rden_overlap", 32'(both_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
